time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

User-facing controller for the time-of-day counter. Decodes debounced button pulses into a menu/edit state machine, holds shadow hour/min/sec edit registers and the timezone offset, and issues the one-cycle load handshake (TIME_SETDATA/TIME_SET_FLAG) that reprograms the GMT counter. Sits between the button front-end and the counter. Also produces the local-time view and state/cursor codes consumed by the LCD sequencer.

## Interface
- TZ_RST, +9, timezone offset after reset (hours, signed).
- TZ_MIN, -12, lowest offset.
- TZ_MAX, +14, highest offset.
- CLK  in  1  clock; counter shares this clock.
- RESETN  in  1  asynchronous, active-low reset.
- BTN_MODE / BTN_BACK / BTN_NEXT / BTN_UP / BTN_DOWN  in  1 each  single-cycle pulses, already debounced.
- CUR_TIME  in  18  counter output {1'b0, hour[4:0], min[5:0], sec[5:0]}, GMT.
- TIME_SETDATA  out  18  load value {1'b0, hour, min, sec}, GMT.
- TIME_SET_FLAG  out  1  counter load strobe, one cycle.
- TZ_OFFSET  out  5  committed offset, two's complement.
- DISP_TIME  out  18  local time for display, same packing.
- STATE  out  4  state code for LCD sequencer.
- CURSOR  out  2  0 hour, 1 min, 2 sec, 3 none.
- MENU_SEL  out  1  0 time item, 1 timezone item.

## Operation
- States and codes: RUN 4'b1000, SETUP 4'b0100, TIME_SET 4'b0101, TZ_SET 4'b0110, APPLY 4'b0111 (internal; STATE still reports TIME_SET).
- One button acted on per cycle, priority MODE > BACK > NEXT > UP > DOWN; lower ones ignored.
- RUN: MODE -> SETUP, MENU_SEL=0. Other buttons ignored.
- SETUP: UP/DOWN toggle MENU_SEL. MODE with MENU_SEL=0 -> TIME_SET, shadow <= local(CUR_TIME), CURSOR=0. MODE with MENU_SEL=1 -> TZ_SET, work_tz <= TZ_OFFSET. BACK -> RUN.
- TIME_SET: NEXT cycles CURSOR 0->1->2->0. UP/DOWN modify the selected field with wrap: hour 23<->0, min/sec 59<->0. MODE -> APPLY. BACK -> SETUP, shadow discarded, no load.
- APPLY: TIME_SETDATA = {1'b0, (shadow_hour - TZ_OFFSET) mod 24, shadow_min, shadow_sec}, TIME_SET_FLAG=1; next state RUN.
- TZ_SET: UP/DOWN step work_tz by ±1 with wrap TZ_MAX->TZ_MIN and TZ_MIN->TZ_MAX. MODE commits TZ_OFFSET <= work_tz -> RUN. BACK -> SETUP, discard.
- DISP_TIME: TIME_SET shows shadow. TZ_SET shows CUR_TIME hour + work_tz. Otherwise CUR_TIME hour + TZ_OFFSET. Min/sec always pass through.
- Hour arithmetic: 7-bit signed sum hour + offset, then +24 if negative, -24 if >=24. The result is always in 0..23.
- Reset (any state, including mid-edit or APPLY): STATE=RUN, TZ_OFFSET=TZ_RST, MENU_SEL=0, CURSOR=3, shadow=0, TIME_SET_FLAG=0, TIME_SETDATA=0. The counter reset hour of 15 GMT with +9 gives DISP_TIME 00:00:00.

## Timing
- All outputs except DISP_TIME are registered. DISP_TIME is combinational from registered state and CUR_TIME.
- A button pulse sampled at edge n sets its state/field effect visible after edge n.
- MODE in TIME_SET at edge n puts APPLY in cycles n..n+1. TIME_SET_FLAG is high exactly that one cycle, and the counter loads at edge n+1. CUR_TIME equals TIME_SETDATA from n+1 (no tick that cycle).
- TIME_SET_FLAG is never high outside APPLY. There are no back-to-back loads; a MODE pulse during APPLY is ignored.
- The counter keeps running during TIME_SET. The loaded value is the shadow, not the time elapsed since entry.

## Structure
- Shared package (time_pkg): state codes, CURSOR field indices, TZ_MIN/TZ_MAX/TZ_RST, time packing field positions. The LCD sequencer uses the same codes.
- One sub-module, tz_hour_adj: combinational (hour[4:0], signed offset[4:0], subtract) -> hour mod 24. Instantiated for the display path and the APPLY GMT conversion.
- Top: FSM, shadow registers, work_tz, output registers.

## Test plan
- Reset with CUR_TIME=15:00:00 -> STATE=RUN, TZ_OFFSET=+9, DISP_TIME=00:00:00, TIME_SET_FLAG=0.
- MODE, MODE, UP×3 (hour 0->3), NEXT, DOWN (min 0->59), MODE -> one-cycle TIME_SET_FLAG with TIME_SETDATA hour=18 (3-9+24), min=59, sec=captured; then STATE=RUN.
- TZ_SET from +9: UP×6 -> +14 -> -12, MODE -> TZ_OFFSET=-12; CUR_TIME 05:xx gives DISP_TIME hour 17.
- TIME_SET edit then BACK -> STATE=SETUP, no TIME_SET_FLAG pulse, CUR_TIME continues counting.
- MODE+UP same cycle in TIME_SET -> APPLY only, field unchanged. NEXT+DOWN -> cursor moves only.
- RESETN low during APPLY cycle -> TIME_SET_FLAG drops immediately (async), STATE=RUN, TZ_OFFSET=+9.

Source files
------------

// File: rtl/time_pkg.sv
// Shared codes for the time-set controller and the LCD sequencer: states, cursor
// indices, timezone limits and the packing of the 18-bit time word.
package time_pkg;

  typedef enum logic [3:0] {
    StRun     = 4'b1000,
    StSetup   = 4'b0100,
    StTimeSet = 4'b0101,
    StTzSet   = 4'b0110,
    StApply   = 4'b0111
  } state_e;

  localparam logic [1:0] CurHour = 2'd0;
  localparam logic [1:0] CurMin  = 2'd1;
  localparam logic [1:0] CurSec  = 2'd2;
  localparam logic [1:0] CurNone = 2'd3;

  localparam logic signed [4:0] TZ_RST = 5'sd9;
  localparam logic signed [4:0] TZ_MIN = -5'sd12;
  localparam logic signed [4:0] TZ_MAX = 5'sd14;

  localparam int unsigned TimeW   = 18;
  localparam int unsigned HourLsb = 12;
  localparam int unsigned MinLsb  = 6;
  localparam int unsigned SecLsb  = 0;

  function automatic logic [TimeW-1:0] pack_time(input logic [4:0] hour,
                                                 input logic [5:0] min,
                                                 input logic [5:0] sec);
    return {1'b0, hour, min, sec};
  endfunction

  // Step a field up or down, wrapping between 0 and max_val.
  function automatic logic [5:0] step_wrap(input logic [5:0] val,
                                           input logic [5:0] max_val,
                                           input logic       up);
    if (up) return (val == max_val) ? 6'd0 : val + 6'd1;
    return (val == 6'd0) ? max_val : val - 6'd1;
  endfunction

  function automatic logic signed [4:0] tz_step(input logic signed [4:0] tz,
                                                input logic              up);
    if (up) return (tz == TZ_MAX) ? TZ_MIN : tz + 5'sd1;
    return (tz == TZ_MIN) ? TZ_MAX : tz - 5'sd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button, counter and display signals between the front-end, the time-set
// controller and the counter/LCD side.
interface time_set_ctrl_if;
  import time_pkg::*;

  logic             BTN_MODE;
  logic             BTN_BACK;
  logic             BTN_NEXT;
  logic             BTN_UP;
  logic             BTN_DOWN;
  logic [TimeW-1:0] CUR_TIME;
  logic [TimeW-1:0] TIME_SETDATA;
  logic             TIME_SET_FLAG;
  logic [4:0]       TZ_OFFSET;
  logic [TimeW-1:0] DISP_TIME;
  logic [3:0]       STATE;
  logic [1:0]       CURSOR;
  logic             MENU_SEL;

  modport master (
    output BTN_MODE, BTN_BACK, BTN_NEXT, BTN_UP, BTN_DOWN, CUR_TIME,
    input  TIME_SETDATA, TIME_SET_FLAG, TZ_OFFSET, DISP_TIME, STATE, CURSOR, MENU_SEL
  );

  modport slave (
    input  BTN_MODE, BTN_BACK, BTN_NEXT, BTN_UP, BTN_DOWN, CUR_TIME,
    output TIME_SETDATA, TIME_SET_FLAG, TZ_OFFSET, DISP_TIME, STATE, CURSOR, MENU_SEL
  );

endinterface

// File: rtl/tz_hour_adj.sv
// Applies a signed timezone offset to an hour, add or subtract, result mod 24.
module tz_hour_adj (
  input  logic              hour_in,
  input  logic [4:0]        hour,
  input  logic signed [4:0] offset,
  input  logic              subtract,
  output logic [4:0]        hour_adj
);
  logic signed [6:0] hour_ext;
  logic signed [6:0] off_ext;
  logic signed [6:0] sum;
  logic signed [6:0] wrapped;

  // Operand range keeps the sum within -14..37, so one correction step suffices.
  always_comb begin
    hour_ext = $signed({2'b00, hour});
    off_ext  = $signed({{2{offset[4]}}, offset});
    sum      = subtract ? (hour_ext - off_ext) : (hour_ext + off_ext);
    if (sum < 7'sd0) begin
      wrapped = sum + 7'sd24;
    end else if (sum >= 7'sd24) begin
      wrapped = sum - 7'sd24;
    end else begin
      wrapped = sum;
    end
  end

  assign hour_adj = 5'(wrapped) & {5{hour_in}};
endmodule

// File: rtl/time_set_ctrl.sv
// Menu/edit FSM for setting time of day and timezone; drives the counter load
// handshake and the local-time display view.
module time_set_ctrl
  import time_pkg::*;
(
  input logic            CLK,
  input logic            RESETN,
  time_set_ctrl_if.slave bus
);
  state_e            state_q;
  logic [3:0]        state_code_q;
  logic signed [4:0] tz_q;
  logic signed [4:0] work_tz_q;
  logic              menu_sel_q;
  logic [1:0]        cursor_q;
  logic [4:0]        sh_hour_q;
  logic [5:0]        sh_min_q;
  logic [5:0]        sh_sec_q;
  logic              set_flag_q;
  logic [TimeW-1:0]  set_data_q;

  logic              btn_mode, btn_back, btn_next, btn_up, btn_down;
  logic [4:0]        cur_hour, disp_hour, gmt_hour;
  logic [5:0]        cur_min, cur_sec;
  logic signed [4:0] disp_off;

  // Only the highest-priority button of a cycle is acted on.
  always_comb begin
    btn_mode = bus.BTN_MODE;
    btn_back = bus.BTN_BACK & ~bus.BTN_MODE;
    btn_next = bus.BTN_NEXT & ~(bus.BTN_MODE | bus.BTN_BACK);
    btn_up   = bus.BTN_UP & ~(bus.BTN_MODE | bus.BTN_BACK | bus.BTN_NEXT);
    btn_down = bus.BTN_DOWN & ~(bus.BTN_MODE | bus.BTN_BACK | bus.BTN_NEXT | bus.BTN_UP);
  end

  assign cur_hour = bus.CUR_TIME[HourLsb +: 5];
  assign cur_min  = bus.CUR_TIME[MinLsb +: 6];
  assign cur_sec  = bus.CUR_TIME[SecLsb +: 6];
  assign disp_off = (state_q == StTzSet) ? work_tz_q : tz_q;

  // Local view of the counter; also the source of the shadow on entry to edit.
  tz_hour_adj u_disp_adj (
    .hour_in  (1'b1),
    .hour     (cur_hour),
    .offset   (disp_off),
    .subtract (1'b0),
    .hour_adj (disp_hour)
  );

  tz_hour_adj u_gmt_adj (
    .hour_in  (1'b1),
    .hour     (sh_hour_q),
    .offset   (tz_q),
    .subtract (1'b1),
    .hour_adj (gmt_hour)
  );

  always_comb begin
    if (state_q == StTimeSet || state_q == StApply) begin
      bus.DISP_TIME = pack_time(sh_hour_q, sh_min_q, sh_sec_q);
    end else begin
      bus.DISP_TIME = pack_time(disp_hour, cur_min, cur_sec);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= StRun;
      state_code_q <= StRun;
      tz_q         <= TZ_RST;
      work_tz_q    <= TZ_RST;
      menu_sel_q   <= 1'b0;
      cursor_q     <= CurNone;
      sh_hour_q    <= '0;
      sh_min_q     <= '0;
      sh_sec_q     <= '0;
      set_flag_q   <= 1'b0;
      set_data_q   <= '0;
    end else begin
      set_flag_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (btn_mode) begin
            state_q      <= StSetup;
            state_code_q <= StSetup;
            menu_sel_q   <= 1'b0;
          end
        end
        StSetup: begin
          if (btn_mode && !menu_sel_q) begin
            state_q      <= StTimeSet;
            state_code_q <= StTimeSet;
            sh_hour_q    <= disp_hour;
            sh_min_q     <= cur_min;
            sh_sec_q     <= cur_sec;
            cursor_q     <= CurHour;
          end else if (btn_mode) begin
            state_q      <= StTzSet;
            state_code_q <= StTzSet;
            work_tz_q    <= tz_q;
          end else if (btn_back) begin
            state_q      <= StRun;
            state_code_q <= StRun;
          end else if (btn_up || btn_down) begin
            menu_sel_q <= ~menu_sel_q;
          end
        end
        StTimeSet: begin
          if (btn_mode) begin
            state_q    <= StApply;
            set_flag_q <= 1'b1;
            set_data_q <= pack_time(gmt_hour, sh_min_q, sh_sec_q);
          end else if (btn_back) begin
            state_q      <= StSetup;
            state_code_q <= StSetup;
            cursor_q     <= CurNone;
          end else if (btn_next) begin
            cursor_q <= (cursor_q == CurSec) ? CurHour : cursor_q + 2'd1;
          end else if (btn_up || btn_down) begin
            unique case (cursor_q)
              CurHour: sh_hour_q <= 5'(step_wrap({1'b0, sh_hour_q}, 6'd23, btn_up));
              CurMin:  sh_min_q  <= step_wrap(sh_min_q, 6'd59, btn_up);
              CurSec:  sh_sec_q  <= step_wrap(sh_sec_q, 6'd59, btn_up);
              default: ;
            endcase
          end
        end
        StApply: begin
          // Buttons are ignored here so a held MODE cannot cause a second load.
          state_q      <= StRun;
          state_code_q <= StRun;
          cursor_q     <= CurNone;
        end
        StTzSet: begin
          if (btn_mode) begin
            tz_q         <= work_tz_q;
            state_q      <= StRun;
            state_code_q <= StRun;
          end else if (btn_back) begin
            state_q      <= StSetup;
            state_code_q <= StSetup;
          end else if (btn_up || btn_down) begin
            work_tz_q <= tz_step(work_tz_q, btn_up);
          end
        end
        default: begin
          state_q      <= StRun;
          state_code_q <= StRun;
        end
      endcase
    end
  end

  assign bus.STATE         = state_code_q;
  assign bus.TZ_OFFSET     = tz_q;
  assign bus.MENU_SEL      = menu_sel_q;
  assign bus.CURSOR        = cursor_q;
  assign bus.TIME_SET_FLAG = set_flag_q;
  assign bus.TIME_SETDATA  = set_data_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed button sequences, a simple GMT counter,
// and a rule-level model compared against every output on each falling edge.
module tb_time_set_ctrl;
  logic CLK    = 1'b0;
  logic RESETN = 1'b0;
  time_set_ctrl_if bus ();

  time_set_ctrl dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mod24(input int v);
    return ((v % 24) + 24) % 24;
  endfunction

  function automatic logic [17:0] pk(input int h, input int m, input int s);
    logic [17:0] r;
    r = {1'b0, h[4:0], m[5:0], s[5:0]};
    return r;
  endfunction

  // GMT counter: loads on the strobe, otherwise ticks once per cycle when enabled.
  int c_h = 15, c_m = 0, c_s = 0;
  bit tick_en = 1'b0, ld_req = 1'b0;
  int ld_h = 0, ld_m = 0, ld_s = 0;
  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      c_h <= 15; c_m <= 0; c_s <= 0;
    end else if (bus.TIME_SET_FLAG) begin
      c_h <= int'(bus.TIME_SETDATA[16:12]);
      c_m <= int'(bus.TIME_SETDATA[11:6]);
      c_s <= int'(bus.TIME_SETDATA[5:0]);
    end else if (ld_req) begin
      c_h <= ld_h; c_m <= ld_m; c_s <= ld_s;
    end else if (tick_en) begin
      if (c_s == 59) begin
        c_s <= 0;
        if (c_m == 59) begin c_m <= 0; c_h <= (c_h + 1) % 24; end
        else c_m <= c_m + 1;
      end else c_s <= c_s + 1;
    end
  end
  assign bus.CUR_TIME = pk(c_h, c_m, c_s);

  // Model: 0 run, 1 setup, 2 time edit, 3 tz edit, 4 apply.
  int m_st = 0, m_tz = 9, m_wtz = 9, m_menu = 0, m_cur = 3;
  int m_sh_h = 0, m_sh_m = 0, m_sh_s = 0, m_flag = 0;
  logic [17:0] m_set = '0;

  function automatic logic [3:0] code_of(input int st);
    case (st)
      1:       return 4'b0100;
      2, 4:    return 4'b0101;
      3:       return 4'b0110;
      default: return 4'b1000;
    endcase
  endfunction

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      m_st = 0; m_tz = 9; m_wtz = 9; m_menu = 0; m_cur = 3;
      m_sh_h = 0; m_sh_m = 0; m_sh_s = 0; m_flag = 0; m_set = '0;
    end else begin
      bit mo, ba, ne, up, dn;
      int d;
      mo = bus.BTN_MODE;
      ba = bus.BTN_BACK && !mo;
      ne = bus.BTN_NEXT && !mo && !ba;
      up = bus.BTN_UP && !mo && !ba && !ne;
      dn = bus.BTN_DOWN && !mo && !ba && !ne && !up;
      d  = up ? 1 : -1;
      m_flag = 0;
      case (m_st)
        0: if (mo) begin m_st = 1; m_menu = 0; end
        1: begin
          if (mo && m_menu == 0) begin
            m_st = 2; m_cur = 0;
            m_sh_h = mod24(c_h + m_tz); m_sh_m = c_m; m_sh_s = c_s;
          end else if (mo) begin
            m_st = 3; m_wtz = m_tz;
          end else if (ba) m_st = 0;
          else if (up || dn) m_menu = 1 - m_menu;
        end
        2: begin
          if (mo) begin
            m_st = 4; m_flag = 1;
            m_set = pk(mod24(m_sh_h - m_tz), m_sh_m, m_sh_s);
          end else if (ba) begin
            m_st = 1; m_cur = 3;
          end else if (ne) m_cur = (m_cur + 1) % 3;
          else if (up || dn) begin
            if (m_cur == 0) m_sh_h = mod24(m_sh_h + d);
            else if (m_cur == 1) m_sh_m = (m_sh_m + d + 60) % 60;
            else m_sh_s = (m_sh_s + d + 60) % 60;
          end
        end
        3: begin
          if (mo) begin m_tz = m_wtz; m_st = 0; end
          else if (ba) m_st = 1;
          else if (up || dn) m_wtz = ((m_wtz + 12 + d + 27) % 27) - 12;
        end
        default: begin m_st = 0; m_cur = 3; end
      endcase
    end
  end

  function automatic logic [17:0] disp_exp();
    if (m_st == 2 || m_st == 4) return pk(m_sh_h, m_sh_m, m_sh_s);
    if (m_st == 3) return pk(mod24(c_h + m_wtz), c_m, c_s);
    return pk(mod24(c_h + m_tz), c_m, c_s);
  endfunction

  always @(negedge CLK) begin
    chk("state", {14'd0, bus.STATE}, {14'd0, code_of(m_st)});
    chk("tz_offset", {13'd0, bus.TZ_OFFSET}, {13'd0, 5'(m_tz)});
    chk("menu_sel", {17'd0, bus.MENU_SEL}, {17'd0, m_menu[0]});
    chk("cursor", {16'd0, bus.CURSOR}, {16'd0, m_cur[1:0]});
    chk("set_flag", {17'd0, bus.TIME_SET_FLAG}, {17'd0, m_flag[0]});
    chk("set_data", bus.TIME_SETDATA, m_set);
    chk("disp_time", bus.DISP_TIME, disp_exp());
  end

  int flag_cnt = 0;
  always @(negedge CLK) if (bus.TIME_SET_FLAG) flag_cnt++;

  localparam logic [4:0] BMode = 5'b10000, BBack = 5'b01000, BNext = 5'b00100;
  localparam logic [4:0] BUp = 5'b00010, BDown = 5'b00001;

  task automatic set_btn(input logic [4:0] b);
    {bus.BTN_MODE, bus.BTN_BACK, bus.BTN_NEXT, bus.BTN_UP, bus.BTN_DOWN} = b;
  endtask

  task automatic press(input logic [4:0] b);
    @(posedge CLK); #2 set_btn(b);
    @(posedge CLK); #2 set_btn(5'b0);
  endtask

  task automatic load_counter(input int h, input int m, input int s);
    @(posedge CLK); #2 ld_h = h; ld_m = m; ld_s = s; ld_req = 1'b1;
    @(posedge CLK); #2 ld_req = 1'b0;
  endtask

  initial begin
    set_btn(5'b0);
    #12;
    chk("rst_state", {14'd0, bus.STATE}, 18'h8);
    chk("rst_tz", {13'd0, bus.TZ_OFFSET}, 18'd9);
    chk("rst_disp", bus.DISP_TIME, pk(0, 0, 0));
    chk("rst_flag", {17'd0, bus.TIME_SET_FLAG}, 18'd0);
    #10 RESETN = 1'b1;

    // Edit time: hour 0->3, min 0->59, then apply.
    press(BMode); press(BMode);
    #1 chk("ts_cursor", {16'd0, bus.CURSOR}, 18'd0);
    repeat (3) press(BUp);
    press(BNext); press(BDown);
    #1 chk("ts_disp", bus.DISP_TIME, pk(3, 59, 0));
    press(BMode);
    #1 chk("apply_flag", {17'd0, bus.TIME_SET_FLAG}, 18'd1);
    chk("apply_data", bus.TIME_SETDATA, pk(18, 59, 0));
    chk("apply_state", {14'd0, bus.STATE}, 18'h5);
    @(posedge CLK); #3;
    chk("post_apply_flag", {17'd0, bus.TIME_SET_FLAG}, 18'd0);
    chk("post_apply_state", {14'd0, bus.STATE}, 18'h8);
    chk("post_apply_disp", bus.DISP_TIME, pk(3, 59, 0));

    // Timezone +9 -> +14 -> wrap to -12.
    press(BMode); press(BUp);
    #1 chk("menu_tz", {17'd0, bus.MENU_SEL}, 18'd1);
    press(BMode);
    repeat (6) press(BUp);
    #1 chk("tz_disp", bus.DISP_TIME, pk(6, 59, 0));
    press(BMode);
    #1 chk("tz_commit", {13'd0, bus.TZ_OFFSET}, 18'h14);
    load_counter(5, 0, 0);
    #1 chk("tz_local", bus.DISP_TIME, pk(17, 0, 0));

    // Edit then back out: no load while the counter keeps running.
    flag_cnt = 0; tick_en = 1'b1;
    press(BMode); press(BMode); press(BUp); press(BBack);
    #1 chk("back_state", {14'd0, bus.STATE}, 18'h4);
    repeat (3) @(posedge CLK);
    chk("back_no_load", 18'(flag_cnt), 18'd0);
    tick_en = 1'b0;
    press(BBack);
    #1 chk("back_run", {14'd0, bus.STATE}, 18'h8);

    // Simultaneous buttons; MODE held into APPLY must not reload.
    load_counter(5, 10, 20);
    press(BMode); press(BMode);
    #1 chk("cap_disp", bus.DISP_TIME, pk(17, 10, 20));
    press(BNext | BDown);
    #1 chk("nd_cursor", {16'd0, bus.CURSOR}, 18'd1);
    chk("nd_disp", bus.DISP_TIME, pk(17, 10, 20));
    @(posedge CLK); #2 set_btn(BMode | BUp);
    @(posedge CLK); #2 set_btn(BMode);
    #1 chk("mu_data", bus.TIME_SETDATA, pk(5, 10, 20));
    @(posedge CLK); #2 set_btn(5'b0);
    #1 chk("mu_flag_drop", {17'd0, bus.TIME_SET_FLAG}, 18'd0);
    @(posedge CLK); #3 chk("mu_stay_run", {14'd0, bus.STATE}, 18'h8);

    // Reset during APPLY.
    press(BMode); press(BMode); press(BMode);
    #1 chk("pre_rst_flag", {17'd0, bus.TIME_SET_FLAG}, 18'd1);
    RESETN = 1'b0;
    #1 chk("arst_flag", {17'd0, bus.TIME_SET_FLAG}, 18'd0);
    chk("arst_state", {14'd0, bus.STATE}, 18'h8);
    chk("arst_tz", {13'd0, bus.TZ_OFFSET}, 18'd9);
    chk("arst_cursor", {16'd0, bus.CURSOR}, 18'd3);
    @(negedge CLK); #1 RESETN = 1'b1;
    repeat (3) @(posedge CLK);
    #1 chk("arst_disp", bus.DISP_TIME, pk(0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
